// File: rtl/simon_io_pkg.sv
// Shared mode codes, controller state type and width helper for the SIMON serial front end.
package simon_io_pkg;

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_PT   = 2'd1;
  localparam logic [1:0] MODE_KEY  = 2'd2;
  localparam logic [1:0] MODE_RUN  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_UNLOAD,
    ST_DONE
  } state_t;

  // Ceiling log2, used to size beat counters.
  function automatic int clog2(input int unsigned n);
    int r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/simon_lane_shreg.sv
// Lane-wide right shift register: new beats enter at the top, so after WIDTH/IO_W
// beats the first beat sits in q[IO_W-1:0].
module simon_lane_shreg #(
  parameter int WIDTH = 128,
  parameter int IO_W  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic [IO_W-1:0]  lane_in,
  output logic [WIDTH-1:0] q
);

  if (WIDTH > IO_W) begin : g_shift
    // Shift one lane beat in from the MSB end while enabled.
    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (shift_en) begin
        q <= {lane_in, q[WIDTH-1:IO_W]};
      end
    end
  end else begin : g_single
    // Register is exactly one beat wide: each beat replaces it.
    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (shift_en) begin
        q <= lane_in;
      end
    end
  end

endmodule

// File: rtl/simon_serial_frontend.sv
// Serial load / parallel launch / serial unload controller for SIMON cores.
module simon_serial_frontend
  import simon_io_pkg::*;
#(
  parameter int BLOCK_W = 128,
  parameter int KEY_W   = 128,
  parameter int IO_W    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IO_W-1:0]    data_in,
  input  logic [1:0]         data_rdy,
  output logic [IO_W-1:0]    data_out,
  output logic               out_valid,
  output logic               busy,
  output logic               err,
  output logic [BLOCK_W-1:0] pt_out,
  output logic [KEY_W-1:0]   key_out,
  output logic               core_start,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] ct_in
);

  localparam int PT_BEATS  = BLOCK_W / IO_W;
  localparam int KEY_BEATS = KEY_W / IO_W;
  localparam int MAX_BEATS = (PT_BEATS > KEY_BEATS) ? PT_BEATS : KEY_BEATS;
  localparam int CNT_W     = clog2(MAX_BEATS + 1);
  localparam int SEL_W     = (PT_BEATS > 1) ? clog2(PT_BEATS) : 1;

  localparam logic [CNT_W-1:0] PT_LAST  = CNT_W'(PT_BEATS - 1);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BEATS - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(PT_BEATS - 1);

  if ((BLOCK_W % IO_W) != 0 || (KEY_W % IO_W) != 0) begin : g_bad_io_w
    $error("IO_W must divide both BLOCK_W and KEY_W");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_eff;
  logic [1:0]         prev_mode;
  logic               pt_full;
  logic               key_full;
  logic [SEL_W-1:0]   idx;
  logic [BLOCK_W-1:0] ct;
  logic [IO_W-1:0]    ct_beat [PT_BEATS];
  logic               pt_shift;
  logic               key_shift;

  assign pt_shift  = (state == ST_IDLE) && (data_rdy == MODE_PT);
  assign key_shift = (state == ST_IDLE) && (data_rdy == MODE_KEY);

  simon_lane_shreg #(.WIDTH(BLOCK_W), .IO_W(IO_W)) u_pt_shreg (
    .clk      (clk),
    .rst      (rst),
    .shift_en (pt_shift),
    .lane_in  (data_in),
    .q        (pt_out)
  );

  simon_lane_shreg #(.WIDTH(KEY_W), .IO_W(IO_W)) u_key_shreg (
    .clk      (clk),
    .rst      (rst),
    .shift_en (key_shift),
    .lane_in  (data_in),
    .q        (key_out)
  );

  // The shared beat counter restarts whenever the mode differs from last cycle's.
  always_comb begin
    cnt_eff = (prev_mode == data_rdy) ? cnt : '0;
  end

  // Split the ciphertext into lane beats; ct itself is never shifted.
  always_comb begin
    for (int unsigned i = 0; i < PT_BEATS; i++) begin
      ct_beat[i] = ct[i*IO_W +: IO_W];
    end
  end

  // Unload beats are gated by the live mode so a stall drops valid in the same cycle.
  always_comb begin
    out_valid = (state == ST_UNLOAD) && (data_rdy == MODE_RUN);
    data_out  = out_valid ? ct_beat[idx] : '0;
  end

  // Controller: load counting, run launch, core wait, unload indexing and release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      prev_mode  <= MODE_IDLE;
      pt_full    <= 1'b0;
      key_full   <= 1'b0;
      idx        <= '0;
      ct         <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
      core_start <= 1'b0;
    end else begin
      core_start <= 1'b0;
      prev_mode  <= data_rdy;
      case (state)
        ST_IDLE: begin
          case (data_rdy)
            MODE_PT: begin
              if (cnt_eff == PT_LAST) pt_full <= 1'b1;
              cnt <= (cnt_eff == PT_LAST) ? cnt_eff : cnt_eff + CNT_W'(1);
            end
            MODE_KEY: begin
              if (cnt_eff == KEY_LAST) key_full <= 1'b1;
              cnt <= (cnt_eff == KEY_LAST) ? cnt_eff : cnt_eff + CNT_W'(1);
            end
            MODE_RUN: begin
              cnt <= '0;
              if (pt_full && key_full) begin
                core_start <= 1'b1;
                busy       <= 1'b1;
                state      <= ST_WAIT;
              end else begin
                err <= 1'b1;
              end
            end
            default: cnt <= '0;
          endcase
        end
        ST_WAIT: begin
          if (core_done) begin
            ct    <= ct_in;
            idx   <= '0;
            state <= ST_UNLOAD;
          end
        end
        ST_UNLOAD: begin
          if (data_rdy == MODE_RUN) begin
            if (idx == IDX_LAST) begin
              busy  <= 1'b0;
              state <= ST_DONE;
            end else begin
              idx <= idx + SEL_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (data_rdy == MODE_IDLE) begin
            pt_full  <= 1'b0;
            key_full <= 1'b0;
            cnt      <= '0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_serial_frontend.sv
// Bench for simon_serial_frontend: three parameter sets share one driver, a stub core
// answers pt ^ key after a fixed delay, and a lane-level model checks reassembled output.
module tb_simon_serial_frontend;

  localparam int LAT = 5;

  typedef struct {
    int           sel;
    logic [127:0] pt;
    logic [127:0] key;
    int           extra;
    int           stall_at;
    int           stall_len;
    logic [127:0] exp_ct;
  } vec_t;

  int bw_of  [3] = '{128, 128, 64};
  int kw_of  [3] = '{128, 128, 96};
  int iow_of [3] = '{1, 8, 4};

  logic         clk;
  logic         rst;
  logic [1:0]   data_rdy;
  logic [7:0]   din;
  logic         core_done_g;
  logic [127:0] ct_g;
  int           sel;

  logic [1:0]   rdy_a, rdy_b, rdy_c;
  logic         cd_a, cd_b, cd_c;
  logic [0:0]   dout_a;
  logic [7:0]   dout_b;
  logic [3:0]   dout_c;
  logic         ov_a, ov_b, ov_c, busy_a, busy_b, busy_c;
  logic         err_a, err_b, err_c, cs_a, cs_b, cs_c;
  logic [127:0] pt_a, pt_b, key_a, key_b;
  logic [63:0]  pt_c;
  logic [95:0]  key_c;

  logic [7:0]   dout_g;
  logic         ov_g, busy_g, err_g, cs_g;
  logic [127:0] pt_g, key_g;

  assign rdy_a = (sel == 0) ? data_rdy : 2'd0;
  assign rdy_b = (sel == 1) ? data_rdy : 2'd0;
  assign rdy_c = (sel == 2) ? data_rdy : 2'd0;
  assign cd_a  = core_done_g && (sel == 0);
  assign cd_b  = core_done_g && (sel == 1);
  assign cd_c  = core_done_g && (sel == 2);

  simon_serial_frontend #(.BLOCK_W(128), .KEY_W(128), .IO_W(1)) u_a (
    .clk(clk), .rst(rst), .data_in(din[0:0]), .data_rdy(rdy_a), .data_out(dout_a),
    .out_valid(ov_a), .busy(busy_a), .err(err_a), .pt_out(pt_a), .key_out(key_a),
    .core_start(cs_a), .core_done(cd_a), .ct_in(ct_g)
  );

  simon_serial_frontend #(.BLOCK_W(128), .KEY_W(128), .IO_W(8)) u_b (
    .clk(clk), .rst(rst), .data_in(din), .data_rdy(rdy_b), .data_out(dout_b),
    .out_valid(ov_b), .busy(busy_b), .err(err_b), .pt_out(pt_b), .key_out(key_b),
    .core_start(cs_b), .core_done(cd_b), .ct_in(ct_g)
  );

  simon_serial_frontend #(.BLOCK_W(64), .KEY_W(96), .IO_W(4)) u_c (
    .clk(clk), .rst(rst), .data_in(din[3:0]), .data_rdy(rdy_c), .data_out(dout_c),
    .out_valid(ov_c), .busy(busy_c), .err(err_c), .pt_out(pt_c), .key_out(key_c),
    .core_start(cs_c), .core_done(cd_c), .ct_in(ct_g[63:0])
  );

  always_comb begin
    dout_g = '0; ov_g = 1'b0; busy_g = 1'b0; err_g = 1'b0; cs_g = 1'b0;
    pt_g = '0; key_g = '0;
    case (sel)
      0: begin
        dout_g = {7'b0, dout_a}; ov_g = ov_a; busy_g = busy_a; err_g = err_a;
        cs_g = cs_a; pt_g = pt_a; key_g = key_a;
      end
      1: begin
        dout_g = dout_b; ov_g = ov_b; busy_g = busy_b; err_g = err_b;
        cs_g = cs_b; pt_g = pt_b; key_g = key_b;
      end
      default: begin
        dout_g = {4'b0, dout_c}; ov_g = ov_c; busy_g = busy_c; err_g = err_c;
        cs_g = cs_c; pt_g = {64'b0, pt_c}; key_g = {32'b0, key_c};
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cycles = 0;
  int         first_v, last_v, n_starts, stub_cnt;
  logic       last_ov;
  logic [7:0] got[$];

  function automatic logic [127:0] blk_mask(input int w);
    return (w >= 128) ? '1 : ((128'd1 << w) - 128'd1);
  endfunction

  // Reference: the core under test is a stub returning pt ^ key truncated to the block.
  function automatic logic [127:0] ct_model(input logic [127:0] pt, input logic [127:0] key,
                                            input int bw);
    return (pt ^ key) & blk_mask(bw);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock cycle: apply inputs, sample outputs mid-cycle, step the stub core after the edge.
  task automatic cyc(input logic [1:0] mode, input logic [7:0] beat);
    data_rdy = mode;
    din      = beat;
    #2;
    last_ov = ov_g;
    if (ov_g) begin
      got.push_back(dout_g);
      if (first_v < 0) first_v = cycles;
      last_v = cycles;
    end
    if (cs_g) begin
      n_starts++;
      stub_cnt = LAT;
      ct_g = ct_model(pt_g, key_g, bw_of[sel]);
    end
    @(posedge clk);
    #1;
    cycles++;
    core_done_g = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) core_done_g = 1'b1;
    end
  endtask

  // Send `extra` junk beats, then the value LSB-beat first.
  task automatic load(input logic [127:0] v, input int nbeats, input int iow,
                      input logic [1:0] mode, input int extra);
    logic [7:0] bm;
    bm = 8'((1 << iow) - 1);
    for (int j = 0; j < extra; j++) cyc(mode, 8'($urandom) & bm);
    for (int k = 0; k < nbeats; k++) cyc(mode, 8'(v >> (k * iow)) & bm);
  endtask

  task automatic run_scn(input vec_t r, input logic err_exp);
    int bw, kw, iow, beats, guard;
    logic stalled;
    logic [127:0] ct_act;
    bw = bw_of[r.sel]; kw = kw_of[r.sel]; iow = iow_of[r.sel];
    beats = bw / iow;
    sel = r.sel;
    cyc(2'd0, 8'd0);
    n_starts = 0; got.delete(); first_v = -1; last_v = -1;
    load(r.pt, bw / iow, iow, 2'd1, r.extra);
    load(r.key, kw / iow, iow, 2'd2, 0);
    cyc(2'd0, 8'd0);
    cyc(2'd3, 8'd0);
    chk("core_start_after_run", cs_g, 1);
    chk("busy_after_run", busy_g, 1);
    chk("pt_out", pt_g, r.pt);
    chk("key_out", key_g, r.key);
    guard = 0; stalled = 1'b0;
    while (got.size() < beats && guard < beats + r.stall_len + 40) begin
      if (!stalled && r.stall_at >= 0 && got.size() == r.stall_at + 1) begin
        stalled = 1'b1;
        for (int s = 0; s < r.stall_len; s++) begin
          cyc(2'd0, 8'd0);
          chk("stall_valid", last_ov, 0);
        end
      end else begin
        cyc(2'd3, 8'd0);
      end
      guard++;
    end
    chk("beat_count", got.size(), beats);
    chk("busy_after_unload", busy_g, 0);
    ct_act = '0;
    foreach (got[k]) ct_act = ct_act | (128'(got[k]) << (k * iow));
    chk("ciphertext", ct_act, r.exp_ct);
    chk("out_span", last_v - first_v + 1, beats + (stalled ? r.stall_len : 0));
    chk("start_pulses", n_starts, 1);
    chk("err_flag", err_g, err_exp);
    cyc(2'd3, 8'd0);
    chk("done_no_valid", last_ov, 0);
    cyc(2'd0, 8'd0);
  endtask

  localparam logic [127:0] NSA_PT  = 128'h63736564207372656c6c657661727420;
  localparam logic [127:0] NSA_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] NSA_CT  = 128'h6c7d68682b797b6d6b6a607262707520;

  vec_t tbl[$];

  initial begin
    vec_t v;
    int   bw, kw, beats;

    sel = 0; rst = 1'b1; data_rdy = 2'd0; din = '0;
    core_done_g = 1'b0; ct_g = '0; stub_cnt = 0; first_v = -1; last_v = -1; n_starts = 0;

    tbl.push_back('{0, NSA_PT, NSA_KEY, 0, -1, 0, NSA_CT});
    tbl.push_back('{1, NSA_PT, NSA_KEY, 0, -1, 0, NSA_CT});
    tbl.push_back('{0, NSA_PT, NSA_KEY, 2, 40, 3, NSA_CT});
    tbl.push_back('{2, 128'h656b696c20646e75, 128'h0d0c0b0a0908050403020100, 0, -1, 0,
                    128'h6c636c6823666f75});
    for (int i = 0; i < 6; i++) begin
      v.sel = $urandom_range(0, 2);
      bw = bw_of[v.sel]; kw = kw_of[v.sel]; beats = bw / iow_of[v.sel];
      v.pt  = {$urandom, $urandom, $urandom, $urandom} & blk_mask(bw);
      v.key = {$urandom, $urandom, $urandom, $urandom} & blk_mask(kw);
      v.extra = $urandom_range(0, 3);
      v.stall_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, beats - 2)) : -1;
      v.stall_len = $urandom_range(1, 4);
      v.exp_ct = ct_model(v.pt, v.key, bw);
      tbl.push_back(v);
    end

    cyc(2'd0, 8'd0);
    cyc(2'd0, 8'd0);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset_outputs", {dout_g, ov_g, busy_g, err_g, cs_g}, 0);
      chk("reset_regs", pt_g | key_g, 0);
    end
    sel = 0;
    rst = 1'b0;

    foreach (tbl[i]) run_scn(tbl[i], 1'b0);

    // Run with only plaintext loaded: err rises, nothing launches, a later full run still works.
    sel = 0;
    cyc(2'd0, 8'd0);
    n_starts = 0;
    load(NSA_PT, 128, 1, 2'd1, 0);
    cyc(2'd0, 8'd0);
    chk("err_before_run", err_g, 0);
    cyc(2'd3, 8'd0);
    chk("err_after_bad_run", err_g, 1);
    chk("no_start_bad_run", cs_g, 0);
    chk("no_busy_bad_run", busy_g, 0);
    repeat (3) cyc(2'd3, 8'd0);
    chk("no_start_pulses", n_starts, 0);
    run_scn(tbl[0], 1'b1);

    // Reset while waiting on the core; the late core_done must be ignored.
    sel = 0;
    load(NSA_PT, 128, 1, 2'd1, 0);
    load(NSA_KEY, 128, 1, 2'd2, 0);
    cyc(2'd0, 8'd0);
    cyc(2'd3, 8'd0);
    chk("start_before_abort", cs_g, 1);
    cyc(2'd0, 8'd0);
    rst = 1'b1;
    cyc(2'd0, 8'd0);
    rst = 1'b0;
    got.delete();
    for (int i = 0; i < LAT + 6; i++) begin
      cyc(2'd0, 8'd0);
      chk("abort_outputs", {dout_g, last_ov, busy_g, err_g, cs_g}, 0);
    end
    chk("abort_regs", pt_g | key_g, 0);
    chk("abort_no_beats", got.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/simon_serial_frontend.md
Name: simon_serial_frontend

Overview:
Parametrised serial I/O controller for SIMON block cipher cores. It deserialises plaintext and key from an IO_W-bit lane, launches a parallel core through a start/done handshake, and reserialises the ciphertext LSB-first with an explicit valid flag. It generalises the existing 1-bit, 2-bit-mode serial interface to arbitrary block, key and lane widths. It adds misuse detection and output back-pressure. It sits between the chip pads and any SIMON core variant.

Parameters:
BLOCK_W, 128, cipher block width in bits (32/48/64/96/128)
KEY_W, 128, key width in bits (64..256)
IO_W, 1, lane width in bits per beat; must divide BLOCK_W and KEY_W (elaboration error otherwise)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
data_in  in  IO_W  serial input lane, LSB-first beats
data_rdy  in  2  mode: 0 idle, 1 load plaintext, 2 load key, 3 run/unload
data_out  out  IO_W  serial ciphertext lane, LSB-first beats
out_valid  out  1  data_out carries a ciphertext beat this cycle
busy  out  1  high from core_start until unload complete
err  out  1  sticky: run requested with plaintext or key not fully loaded
pt_out  out  BLOCK_W  parallel plaintext to core
key_out  out  KEY_W  parallel key to core
core_start  out  1  one-cycle launch pulse to core
core_done  in  1  one-cycle completion pulse from core
ct_in  in  BLOCK_W  parallel ciphertext from core, valid with core_done

Behaviour:
- Reset: state IDLE; pt/key/ct registers 0; beat counters 0; pt_full=key_full=0. Outputs: data_out=0, out_valid=0, busy=0, err=0, core_start=0. Reset mid-operation aborts immediately; a core_done arriving afterwards is ignored.
- States: IDLE, WAIT_CORE, UNLOAD, DONE.
- IDLE, data_rdy=1: each cycle pt <= {data_in, pt[BLOCK_W-1:IO_W]}. After BLOCK_W/IO_W beats, beat 0 lands in pt[IO_W-1:0]. pt_full is set on the final beat.
  - Extra beats keep shifting; only the last BLOCK_W/IO_W beats are retained, and pt_full stays set.
- IDLE, data_rdy=2: key loads the same way with KEY_W/IO_W beats and sets key_full.
- Any change of data_rdy between 1 and 2, or to 0, clears the shared beat counter. The full flags are not cleared.
- IDLE, data_rdy=3 sampled at edge t:
  - Both full flags set: core_start=1 and busy=1 during cycle t+1 (registered); next state WAIT_CORE.
  - Otherwise: err set during t+1, stays IDLE, no start. err clears only on rst.
- WAIT_CORE: pt_out/key_out are held stable. data_rdy is ignored, because the core cannot be aborted.
  - core_done at edge c: ct <= ct_in; next state UNLOAD; beat index 0.
- UNLOAD: data_out = ct[IO_W*idx +: IO_W] with out_valid=1. First beat appears at cycle c+1.
  - idx advances only while data_rdy=3. If data_rdy!=3, out_valid=0, data_out=0, and idx is held (stall).
  - After the last beat (idx = BLOCK_W/IO_W-1 consumed), next state DONE, busy=0.
- DONE: out_valid=0, data_out=0. When data_rdy=0 is sampled, go to IDLE and clear pt_full, key_full and the counter. Registers keep their contents.
- core_done outside WAIT_CORE is ignored. core_start is never high two cycles in a row.
- Throughput: minimum cycles from the run request to the last out beat = 1 + core latency + BLOCK_W/IO_W.

Decomposition:
- Package simon_io_pkg:
  - mode constants MODE_IDLE=2'd0, MODE_PT=2'd1, MODE_KEY=2'd2, MODE_RUN=2'd3
  - state encoding ST_IDLE, ST_WAIT, ST_UNLOAD, ST_DONE
  - function clog2 for counter widths
- One sub-module, simon_lane_shreg (params WIDTH, IO_W; ports clk, rst, shift_en, lane_in, q). Instantiated for pt and key.
- The ct unload uses an indexed mux in the top level rather than a shifter, so ct stays intact for debug.

Test Plan:
- NSA load, IO_W=1, stub core returning pt^key after 5 cycles. Load pt=63736564207372656c6c657661727420 (128 beats), key=0f0e0d0c0b0a09080706050403020100, data_rdy=0 for 1 cycle, then 3. Expect: core_start one cycle after the 3 is sampled; 128 out_valid beats reassembling to 6c7d68682b797b6d6b6a607262707520; busy low after the last beat.
- Same vectors with IO_W=8 (16 beats each) -> identical ct, and the out phase lasts exactly 16 valid cycles.
- Run with only pt loaded (key 0 beats) -> err=1 one cycle later, core_start never pulses, state IDLE. A later full load plus run still works and err stays 1.
- Stall: drop data_rdy to 0 for 3 cycles after out beat 40 -> out_valid low for those cycles, then beats 41..127 resume with no loss or duplication.
- Overload: 130 plaintext beats -> pt holds the last 128 beats. rst asserted during WAIT_CORE, then core_done -> all outputs 0, no out_valid.
- BLOCK_W=64, KEY_W=96, IO_W=4: pt=656b696c20646e75, key=0d0c0b0a0908050403020100 with stub core -> ct = pt ^ key[63:0] over 16 beats.
